// File: rtl/imm_instr_encoder_if.sv
// Request/response bundle for the immediate instruction encoder.
// The loader (master) issues requests and consumes encoded words.
interface imm_instr_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        immsrc;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic [31:0]       imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       instr_out;
   logic              err;
   logic [ADDR_W-1:0] wr_addr;

   modport master (
      output in_valid, immsrc, opcode, rd, rs1, rs2,
      output funct3, imm, out_ready,
      input  in_ready, out_valid, instr_out, err, wr_addr
   );

   modport slave (
      input  in_valid, immsrc, opcode, rd, rs1, rs2,
      input  funct3, imm, out_ready,
      output in_ready, out_valid, instr_out, err, wr_addr
   );
endinterface

// File: rtl/imm_instr_encoder.sv
// Packs opcode/regs/funct3/immediate into a RISC-V word via immsrc.
// Two-stage pipeline: S1 holds request + legality, S2 holds the word.
module imm_instr_encoder #(
   parameter int              ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic                clk,
   input logic                rst_n,
   imm_instr_encoder_if.slave bus
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [2:0]  immsrc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic        ok;
   } s1_t;

   s1_t               s1_q, s1_d;
   logic              s1_valid_q, s1_valid_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       instr_q, instr_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

   logic        s2_adv;
   logic        in_ok;
   logic        fits12, fits13, fits21;
   logic [31:0] ii, im, enc;

   assign s2_adv      = !out_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid_q || s2_adv;

   // Signed range == upper bits all copies of the sign bit.
   assign ii     = bus.imm;
   assign fits12 = (&ii[31:11]) | ~(|ii[31:11]);
   assign fits13 = (&ii[31:12]) | ~(|ii[31:12]);
   assign fits21 = (&ii[31:20]) | ~(|ii[31:20]);

   always_comb begin
      in_ok = 1'b0;
      unique case (bus.immsrc)
         3'b000,
         3'b001:  in_ok = fits12;
         3'b010:  in_ok = fits13 & ~ii[0];
         3'b011:  in_ok = fits21 & ~ii[0];
         3'b100:  in_ok = ~(|ii[11:0]);
         default: in_ok = 1'b0;
      endcase
   end

   assign im = s1_q.imm;

   always_comb begin
      enc = NOP;
      unique case (s1_q.immsrc)
         3'b000: enc = {im[11:0], s1_q.rs1, s1_q.funct3,
                        s1_q.rd, s1_q.opcode};
         3'b001: enc = {im[11:5], s1_q.rs2, s1_q.rs1,
                        s1_q.funct3, im[4:0], s1_q.opcode};
         3'b010: enc = {im[12], im[10:5], s1_q.rs2, s1_q.rs1,
                        s1_q.funct3, im[4:1], im[11],
                        s1_q.opcode};
         3'b011: enc = {im[20], im[10:1], im[11], im[19:12],
                        s1_q.rd, s1_q.opcode};
         3'b100: enc = {im[31:12], s1_q.rd, s1_q.opcode};
         default: enc = NOP;
      endcase
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      err_d       = err_q;
      wr_addr_d   = wr_addr_q;
      if (bus.in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_d.immsrc = bus.immsrc;
            s1_d.opcode = bus.opcode;
            s1_d.rd     = bus.rd;
            s1_d.rs1    = bus.rs1;
            s1_d.rs2    = bus.rs2;
            s1_d.funct3 = bus.funct3;
            s1_d.imm    = bus.imm;
            s1_d.ok     = in_ok;
         end
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            instr_d = s1_q.ok ? enc : NOP;
            err_d   = !s1_q.ok;
         end
      end
      if (out_valid_q && bus.out_ready)
         wr_addr_d = wr_addr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         err_q       <= 1'b0;
         wr_addr_q   <= BASE_ADDR;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         err_q       <= err_d;
         wr_addr_q   <= wr_addr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.instr_out = instr_q;
   assign bus.err       = err_q;
   assign bus.wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed bench for imm_instr_encoder: encodings, legality,
// backpressure, address wrap and asynchronous reset.
module tb_imm_instr_encoder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   imm_instr_encoder_if #(.ADDR_W(10)) bus ();
   imm_instr_encoder_if #(.ADDR_W(2))  wbus ();

   imm_instr_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   imm_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (wbus)
   );

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_addr;
   logic [31:0] exp_q[$];
   int acc;
   int got;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xact(input string tag, input logic [2:0] src,
                       input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [31:0] imm,
                       input logic [31:0] exp_i, input logic exp_e);
      @(negedge clk);
      bus.immsrc    = src;
      bus.opcode    = op;
      bus.rd        = rd;
      bus.rs1       = rs1;
      bus.rs2       = rs2;
      bus.funct3    = f3;
      bus.imm       = imm;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk({tag, "_inready"}, {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, "_lat1"}, {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_instr"}, bus.instr_out, exp_i);
      chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_e});
      chk({tag, "_addr"}, {22'd0, bus.wr_addr}, {22'd0, exp_addr});
      exp_addr = exp_addr + 10'd1;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.immsrc = '0; bus.opcode = '0; bus.rd = '0;
      bus.rs1 = '0; bus.rs2 = '0; bus.funct3 = '0; bus.imm = '0;
      wbus.in_valid = 1'b0; wbus.out_ready = 1'b0;
      wbus.immsrc = '0; wbus.opcode = '0; wbus.rd = '0;
      wbus.rs1 = '0; wbus.rs2 = '0; wbus.funct3 = '0; wbus.imm = '0;
      exp_addr = '0;

      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_instr", bus.instr_out, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_addr", {22'd0, bus.wr_addr}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_inready", {31'd0, bus.in_ready}, 32'd1);

      xact("i_addi", 3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0,
           32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
      xact("b_beq", 3'b010, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0,
           -32'sd4, 32'hFE20_8EE3, 1'b0);
      xact("u_lui", 3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0,
           32'h1234_5000, 32'h1234_52B7, 1'b0);
      xact("s_sw", 3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2,
           -32'sd4, 32'hFE20_AE23, 1'b0);
      xact("j_jal", 3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0,
           32'd8, 32'h0080_00EF, 1'b0);
      xact("i_min", 3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0,
           -32'sd2048, 32'h8000_0093, 1'b0);
      xact("i_2048", 3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0,
           32'd2048, 32'h0000_0013, 1'b1);
      xact("j_odd", 3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0,
           32'd3, 32'h0000_0013, 1'b1);
      xact("src_111", 3'b111, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0,
           32'd0, 32'h0000_0013, 1'b1);
      xact("b_4096", 3'b010, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0,
           32'd4096, 32'h0000_0013, 1'b1);
      xact("u_low", 3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0,
           32'h1234_5001, 32'h0000_0013, 1'b1);

      // Four back-to-back requests, output stalled for six cycles.
      acc = 0;
      got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         @(negedge clk);
         bus.out_ready = (c >= 6);
         bus.in_valid  = (acc < 4);
         bus.immsrc    = 3'b000;
         bus.opcode    = 7'h13;
         bus.rd        = 5'(acc + 1);
         bus.rs1       = 5'd0;
         bus.rs2       = 5'd0;
         bus.funct3    = 3'd0;
         bus.imm       = 32'(acc);
         #1;
         if (c == 2) begin
            chk("bp_inready_low", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_accepted", 32'(acc), 32'd2);
         end
         if (c == 5) begin
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_instr", bus.instr_out, 32'h0000_0093);
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("bp_instr", bus.instr_out, exp_q.pop_front());
            chk("bp_addr", {22'd0, bus.wr_addr}, {22'd0, exp_addr});
            exp_addr = exp_addr + 10'd1;
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({12'(acc), 5'd0, 3'd0, 5'(acc + 1), 7'h13});
            acc++;
         end
      end
      bus.in_valid = 1'b0;
      chk("bp_count", 32'(got), 32'd4);

      // Reset while S2 holds a word and S1 holds another.
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.immsrc    = 3'b000;
      bus.rd        = 5'd3;
      bus.imm       = 32'd5;
      @(negedge clk);
      bus.imm       = 32'd6;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      chk("mid_valid_pre", {31'd0, bus.out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_addr", {22'd0, bus.wr_addr}, 32'd0);
      chk("mid_instr", bus.instr_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mid_no_stale", {31'd0, bus.out_valid}, 32'd0);
      end
      exp_addr = '0;
      xact("post_rst", 3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0,
           32'h1234_5000, 32'h1234_52B7, 1'b0);

      // Two-bit address wraps after four words.
      wbus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         wbus.immsrc   = 3'b000;
         wbus.opcode   = 7'h13;
         wbus.rd       = 5'd1;
         wbus.imm      = 32'd0;
         wbus.in_valid = 1'b1;
         @(negedge clk);
         wbus.in_valid = 1'b0;
         @(negedge clk);
         chk("wrap_valid", {31'd0, wbus.out_valid}, 32'd1);
         chk("wrap_addr", {30'd0, wbus.wr_addr}, 32'(i % 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
